// File: rtl/microseq_controller.sv
// microseq_controller: microprogram sequencer with a small return-address stack.
// Define MICROSEQ_WATCHDOG_EN to add the WAIT-hold watchdog (limit WD_LIMIT cycles).
module microseq_controller #(
    parameter int                ADDR_W      = 6,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] FETCH_ADDR  = '0,
    parameter int                WD_LIMIT    = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           halt,
    input  logic [ADDR_W-1:0]              decode_addr,
    input  logic [2:0]                     ns_sel,
    input  logic [ADDR_W-1:0]              cr_addr,
    input  logic [1:0]                     cond_sel,
    input  logic                           cond_inv,
    input  logic                           mfc,
    input  logic                           cond_pass,
    output logic [ADDR_W-1:0]              state,
    output logic                           cond_out,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           stack_err,
    output logic                           wd_timeout
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    typedef enum logic [2:0] {
        NS_ENCODE = 3'b000,
        NS_INCR   = 3'b001,
        NS_JUMP   = 3'b010,
        NS_CBR    = 3'b011,
        NS_WAIT   = 3'b100,
        NS_CALL   = 3'b101,
        NS_RET    = 3'b110,
        NS_FETCH  = 3'b111
    } ns_sel_e;

    typedef enum logic [1:0] {
        COND_MFC  = 2'd0,
        COND_PASS = 2'd1,
        COND_ONE  = 2'd2,
        COND_ZERO = 2'd3
    } cond_sel_e;

    if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || (1 << PW) != STACK_DEPTH) begin : g_bad_depth
        $error("STACK_DEPTH must be a power of two in 2..8");
    end
    if (WD_LIMIT < 0 || WD_LIMIT > 255) begin : g_bad_wd_limit
        $error("WD_LIMIT must be in 0..255");
    end

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] state_d;
    logic [ADDR_W-1:0] inc;
    logic [DW-1:0]     depth_d;
    logic [PW-1:0]     top_idx;
    logic              err_d;
    logic              push;
    logic              cond_raw;
    logic              stack_full;
    logic              stack_empty;

`ifdef MICROSEQ_WATCHDOG_EN
    localparam logic [7:0] WD_MAX = 8'(WD_LIMIT);
    logic [7:0] wd_cnt_q;
    logic [7:0] wd_cnt_d;
    logic       wait_hold;
    logic       wd_fire;
    logic       wd_q;
`endif

    always_comb begin
        unique case (cond_sel_e'(cond_sel))
            COND_MFC:  cond_raw = mfc;
            COND_PASS: cond_raw = cond_pass;
            COND_ONE:  cond_raw = 1'b1;
            COND_ZERO: cond_raw = 1'b0;
        endcase
        cond_out = cond_raw ^ cond_inv;
    end

    assign inc         = state + ADDR_W'(1);
    assign top_idx     = PW'(stack_depth - DW'(1));
    assign stack_full  = (stack_depth == DW'(STACK_DEPTH));
    assign stack_empty = (stack_depth == '0);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state;
        depth_d = stack_depth;
        err_d   = stack_err;
        push    = 1'b0;
        unique case (ns_sel_e'(ns_sel))
            NS_ENCODE: state_d = decode_addr;
            NS_INCR:   state_d = inc;
            NS_JUMP:   state_d = cr_addr;
            NS_CBR:    state_d = cond_out ? cr_addr : inc;
            NS_WAIT:   state_d = cond_out ? inc : state;
            NS_CALL: begin
                state_d = cr_addr;
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    depth_d = stack_depth + DW'(1);
                end
            end
            NS_RET: begin
                if (stack_empty) begin
                    state_d = FETCH_ADDR;
                    err_d   = 1'b1;
                end else begin
                    state_d = stack_mem[top_idx];
                    depth_d = stack_depth - DW'(1);
                end
            end
            NS_FETCH:  state_d = FETCH_ADDR;
        endcase

`ifdef MICROSEQ_WATCHDOG_EN
        wd_fire   = 1'b0;
        wait_hold = (ns_sel == NS_WAIT) && !cond_out;
        wd_cnt_d  = wait_hold ? wd_cnt_q + 8'd1 : 8'd0;
        // A hold that has already lasted WD_LIMIT cycles abandons the sequence.
        if (wait_hold && wd_cnt_q == WD_MAX) begin
            state_d  = FETCH_ADDR;
            depth_d  = '0;
            wd_cnt_d = '0;
            wd_fire  = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH_ADDR;
            stack_depth <= '0;
            stack_err   <= 1'b0;
        end else if (!halt) begin
            state       <= state_d;
            stack_depth <= depth_d;
            stack_err   <= err_d;
        end
    end

    // NOTE: the stack array is not reset; entries at or above stack_depth are never read.
    always_ff @(posedge clk) begin
        if (push && !halt) begin
            stack_mem[stack_depth[PW-1:0]] <= inc;
        end
    end

`ifdef MICROSEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            wd_q     <= 1'b0;
        end else if (halt) begin
            wd_q     <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_q     <= wd_fire;
        end
    end

    assign wd_timeout = wd_q & ~halt;
`else
    assign wd_timeout = 1'b0;
`endif

endmodule
